// File: rtl/bus_xfer_engine_if.sv
// bus_xfer_engine_if: request/handshake/data bundle between the top level and bus_xfer_engine
interface bus_xfer_engine_if #(
   parameter int WIDTH  = 4,
   parameter int NREG   = 3,
   parameter int ADDR_W = 4,
   parameter int SEL_W  = 3
);
   logic                   start;
   logic [SEL_W-1:0]       src_sel;
   logic [SEL_W-1:0]       dst_sel;
   logic [ADDR_W-1:0]      src_addr;
   logic [ADDR_W-1:0]      dst_addr;
   logic [ADDR_W-1:0]      len;
   logic [WIDTH-1:0]       ext_din;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [WIDTH-1:0]       bus_out;
   logic [NREG*WIDTH-1:0]  reg_q;
   modport master (output start, src_sel, dst_sel, src_addr, dst_addr, len, ext_din,
                   input busy, done, err, bus_out, reg_q);
   modport slave  (input start, src_sel, dst_sel, src_addr, dst_addr, len, ext_din,
                   output busy, done, err, bus_out, reg_q);
endinterface

// File: rtl/bus_xfer_engine.sv
// bus_xfer_engine: register/RAM/ext shared-bus move sequencer with block copy
// Optional word counter output xfer_cnt when BUS_XFER_COUNT_EN is defined.
module bus_xfer_engine #(
   parameter int WIDTH  = 4,
   parameter int NREG   = 3,
   parameter int ADDR_W = 4,
   parameter int SEL_W  = 3
) (
   input logic clk,
   input logic rst_n,
   bus_xfer_engine_if.slave bus
`ifdef BUS_XFER_COUNT_EN
   ,
   output logic [7:0] xfer_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
   localparam logic [SEL_W-1:0] RAM_SEL = SEL_W'(NREG);
   localparam logic [SEL_W-1:0] EXT_SEL = SEL_W'(NREG + 1);
   state_t state, state_nx;
   logic [SEL_W-1:0] w_src, w_dst;
   logic [ADDR_W-1:0] w_sa, w_da, w_len;
   logic err_q, illegal;
   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] ram [2**ADDR_W];
   logic [WIDTH-1:0] bus_q, src_v;
   assign illegal = bus.src_sel > EXT_SEL || bus.dst_sel > RAM_SEL;
   always_comb begin
      src_v = w_src == RAM_SEL ? ram[w_sa] : bus.ext_din;
      for (int i = 0; i < NREG; i++) if (w_src == SEL_W'(i)) src_v = regs[i];
   end
   always_comb begin
      state_nx = state;
      bus.busy = state == READ || state == WRITE;
      bus.done = state == FIN;
      bus.err  = state == FIN && err_q;
      unique case (state)
         IDLE:    state_nx = bus.start ? (illegal ? FIN : READ) : IDLE;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = w_len == '0 ? FIN : READ;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         w_src <= '0;
         w_dst <= '0;
         w_sa  <= '0;
         w_da  <= '0;
         w_len <= '0;
         err_q <= 1'b0;
         bus_q <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.start) begin
            w_src <= bus.src_sel;
            w_dst <= bus.dst_sel;
            w_sa  <= bus.src_addr;
            w_da  <= bus.dst_addr;
            w_len <= bus.len;
            err_q <= illegal;
         end
         if (state == READ) bus_q <= src_v;
         if (state == WRITE) begin
            for (int i = 0; i < NREG; i++) if (w_dst == SEL_W'(i)) regs[i] <= bus_q;
            // pointers only advance on the RAM side; register sides repeat
            if (w_len != '0) begin
               w_len <= w_len - ADDR_W'(1);
               if (w_src == RAM_SEL) w_sa <= w_sa + ADDR_W'(1);
               if (w_dst == RAM_SEL) w_da <= w_da + ADDR_W'(1);
            end
         end
      end
   end
   always_ff @(posedge clk) if (state == WRITE && w_dst == RAM_SEL) ram[w_da] <= bus_q;
   assign bus.bus_out = bus_q;
   for (genvar i = 0; i < NREG; i++) begin : g_regq
      assign bus.reg_q[i*WIDTH +: WIDTH] = regs[i];
   end
`ifdef BUS_XFER_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_cnt <= 8'd0;
      else if (state == WRITE && xfer_cnt != 8'hFF) xfer_cnt <= xfer_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_bus_xfer_engine.sv
// tb_bus_xfer_engine: randomized transfers checked every cycle against a word-level model
module tb_bus_xfer_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   bus_xfer_engine_if ifc ();
`ifdef BUS_XFER_COUNT_EN
   logic [7:0] xfer_cnt;
`endif
   bus_xfer_engine dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(ifc)
`ifdef BUS_XFER_COUNT_EN
      ,
      .xfer_cnt(xfer_cnt)
`endif
   );
   logic [3:0] m_reg [3];
   logic [3:0] m_ram [16];
   logic exp_busy, exp_done, exp_err;
   logic [3:0] exp_bus;
   int m_cnt;
   bit chk_en;
   int checks, failures;
   int cyc, dcyc, bcyc, ndone;
   bit eseen;
   function automatic logic [11:0] m_regq();
      return {m_reg[2], m_reg[1], m_reg[0]};
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) if (chk_en) begin
      chk("busy", 64'(ifc.busy), 64'(exp_busy));
      chk("done", 64'(ifc.done), 64'(exp_done));
      chk("err", 64'(ifc.err), 64'(exp_err));
      chk("bus_out", 64'(ifc.bus_out), 64'(exp_bus));
      chk("reg_q", 64'(ifc.reg_q), 64'(m_regq()));
`ifdef BUS_XFER_COUNT_EN
      chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
   end
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (ifc.busy) bcyc++;
      if (ifc.done) begin
         ndone++;
         if (dcyc < 0) dcyc = cyc;
         if (ifc.err) eseen = 1'b1;
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_reg[i] = 4'h0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_err = 1'b0;
      exp_bus = 4'h0;
      m_cnt = 0;
   endtask
   // called at posedge+1 with the engine idle; returns idle one cycle after done
   task automatic xfer(input int src, input int dst, input int sa, input int da, input int ln,
                       input logic [3:0] ext, input int abort);
      logic [3:0] word;
      bit ill;
      ill = src > 4 || dst > 3;
      ifc.src_sel = 3'(src);
      ifc.dst_sel = 3'(dst);
      ifc.src_addr = 4'(sa);
      ifc.dst_addr = 4'(da);
      ifc.len = 4'(ln);
      ifc.ext_din = ext;
      ifc.start = 1'b1;
      cyc = 0; dcyc = -1; bcyc = 0; ndone = 0; eseen = 1'b0;
      step();
      ifc.start = 1'b0;
      ifc.src_sel = 3'($urandom);
      ifc.dst_sel = 3'($urandom);
      ifc.src_addr = 4'($urandom);
      ifc.dst_addr = 4'($urandom);
      ifc.len = 4'($urandom);
      if (ill) begin
         exp_done = 1'b1;
         exp_err = 1'b1;
         step();
         exp_done = 1'b0;
         exp_err = 1'b0;
         return;
      end
      for (int k = 0; k <= ln; k++) begin
         if (k == abort) begin
            rst_n = 1'b0;
            ifc.start = 1'b0;
            model_reset();
            #1;
            chk("rst_busy", 64'(ifc.busy), 64'd0);
            chk("rst_regs", 64'(ifc.reg_q), 64'd0);
            step();
            rst_n = 1'b1;
            return;
         end
         exp_busy = 1'b1;
         ifc.start = 1'($urandom);
         word = src < 3 ? m_reg[src] : src == 3 ? m_ram[(sa + k) % 16] : ext;
         step();
         exp_bus = word;
         ifc.start = 1'($urandom);
         step();
         if (dst < 3) m_reg[dst] = word;
         else m_ram[(da + k) % 16] = word;
         if (m_cnt < 255) m_cnt++;
      end
      exp_busy = 1'b0;
      exp_done = 1'b1;
      ifc.start = 1'b0;
      step();
      exp_done = 1'b0;
   endtask
   initial begin
      ifc.start = 1'b0;
      ifc.src_sel = '0;
      ifc.dst_sel = '0;
      ifc.src_addr = '0;
      ifc.dst_addr = '0;
      ifc.len = '0;
      ifc.ext_din = '0;
      model_reset();
      checks = 0;
      failures = 0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_regq", 64'(ifc.reg_q), 64'd0);
      chk("reset_bus", 64'(ifc.bus_out), 64'd0);
      rst_n = 1'b1;
      step();
      xfer(4, 1, 0, 0, 0, 4'hA, -1);
      chk("ext_reg1", 64'(ifc.reg_q[7:4]), 64'hA);
      chk("ext_bus", 64'(ifc.bus_out), 64'hA);
      chk("ext_done_cyc", 64'(dcyc), 64'd3);
      chk("ext_busy_cyc", 64'(bcyc), 64'd2);
      chk("ext_ndone", 64'(ndone), 64'd1);
      for (int a = 0; a < 16; a++) xfer(4, 3, 0, a, 0, 4'($urandom), -1);
      xfer(4, 0, 0, 0, 0, 4'h5, -1);
      xfer(0, 3, 0, 14, 3, 4'h0, -1);
      chk("wrap_done_cyc", 64'(dcyc), 64'd9);
      chk("wrap_ndone", 64'(ndone), 64'd1);
      for (int a = 14; a < 18; a++) begin
         xfer(3, 2, a % 16, 0, 0, 4'h0, -1);
         chk("wrap_ram", 64'(ifc.reg_q[11:8]), 64'h5);
      end
      xfer(4, 3, 0, 2, 0, 4'h3, -1);
      xfer(4, 3, 0, 3, 0, 4'h7, -1);
      xfer(4, 3, 0, 4, 0, 4'h9, -1);
      xfer(3, 3, 2, 8, 2, 4'h0, -1);
      chk("r2r_done_cyc", 64'(dcyc), 64'd7);
      for (int a = 0; a < 3; a++) begin
         xfer(3, 1, 8 + a, 0, 0, 4'h0, -1);
         chk("r2r_dst", 64'(ifc.reg_q[7:4]), a == 0 ? 64'h3 : a == 1 ? 64'h7 : 64'h9);
         xfer(3, 1, 2 + a, 0, 0, 4'h0, -1);
         chk("r2r_src", 64'(ifc.reg_q[7:4]), a == 0 ? 64'h3 : a == 1 ? 64'h7 : 64'h9);
      end
      xfer(0, 4, 0, 0, 0, 4'hF, -1);
      chk("ill_done_cyc", 64'(dcyc), 64'd1);
      chk("ill_err", 64'(eseen), 64'd1);
      chk("ill_ndone", 64'(ndone), 64'd1);
      for (int t = 0; t < 60; t++) begin
         int ln;
         ln = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2);
         xfer($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 15),
              $urandom_range(0, 15), ln, 4'($urandom), -1);
      end
      xfer(3, 0, 0, 0, 9, 4'h0, 3);
      step();
      chk("post_rst_regq", 64'(ifc.reg_q), 64'd0);
`ifdef BUS_XFER_COUNT_EN
      xfer(4, 3, 0, 0, 15, 4'h6, -1);
      xfer(4, 1, 0, 0, 0, 4'h2, -1);
      chk("xfer_cnt_17", 64'(xfer_cnt), 64'd17);
`endif
      for (int t = 0; t < 20; t++)
         xfer($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 4), 4'($urandom), -1);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bus_xfer_engine.md
Name: bus_xfer_engine

Overview:
- Parametrised successor to the lab bus datapath: NREG general registers, one 2^ADDR_W-deep RAM and an external input share one WIDTH-bit bus.
- A sequencer FSM performs source-to-destination moves with a start/busy/done handshake.
- Supports single-word moves and auto-incrementing block copies (RAM↔register, RAM→RAM).
- Sits between the switch/LED top level and the storage elements; the top level supplies the clock enable and selections.

Parameters:
- WIDTH, 4: data width of bus, registers, RAM words.
- NREG, 3: number of general registers (1..6).
- ADDR_W, 4: RAM address width; depth = 2^ADDR_W.
- SEL_W, 3: select code width; requires NREG+2 <= 2^SEL_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a transfer; sampled only in IDLE.
- src_sel  in  SEL_W  source: 0..NREG-1 = register i, NREG = RAM, NREG+1 = ext_din.
- dst_sel  in  SEL_W  destination: 0..NREG-1 = register i, NREG = RAM.
- src_addr  in  ADDR_W  RAM start address when the source is RAM.
- dst_addr  in  ADDR_W  RAM start address when the destination is RAM.
- len  in  ADDR_W  word count minus one (0 → 1 word).
- ext_din  in  WIDTH  external data source.
- busy  out  1  high in READ/WRITE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal request, coincident with done.
- bus_out  out  WIDTH  bus latch (last word moved).
- reg_q  out  NREG*WIDTH  all register contents; register i at [i*WIDTH +: WIDTH].

Behaviour:
- FSM states: IDLE, READ, WRITE, FIN.
- IDLE, start=1:
  - Latch src_sel, dst_sel, src_addr, dst_addr, len into working copies; go to READ.
  - Later changes to these inputs have no effect on the transfer in progress.
- Illegal request (src_sel > NREG+1, or dst_sel > NREG-1 and != NREG): go directly to FIN with err=1. No storage is modified.
- READ: bus latch <= selected source. RAM reads use the working src pointer; the RAM read is synchronous into the latch.
- WRITE:
  - Destination <= bus latch. RAM writes use the working dst pointer.
  - If the remaining count is 0, go to FIN. Otherwise decrement the count, increment each pointer whose side is RAM (modulo 2^ADDR_W, wrap 2^ADDR_W-1 → 0), and go to READ.
- FIN: done=1, busy=0 for one cycle, then IDLE.
- Timing:
  - A word takes 2 cycles. A transfer of N words has done asserted at cycle 2N+1 after the start-accept edge.
  - An illegal request has done/err at cycle 1.
- Non-RAM sources/destinations repeat the same register for every word; the last write wins.
- src_sel == dst_sel (register) is legal; the value is unchanged.
- RAM→RAM copies word by word in ascending address order. Overlapping ranges are not corrected; the result is whatever that sequential order produces.
- start while busy or in FIN is ignored; it is not queued.
- Reset values (assertion at any time, including mid-transfer): state IDLE, busy=0, done=0, err=0, bus_out=0, all registers=0. Partial block copies are not rolled back.
- RAM has no reset; contents are undefined until written.

Optional Feature:
- Macro: BUS_XFER_COUNT_EN.
- Defined:
  - Adds output xfer_cnt [7:0], counting words written in WRITE.
  - Saturates at 255.
  - Cleared by rst_n only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with src_sel=4, ext_din=4'hA, dst_sel=1, len=0 → reg_q[7:4]=4'hA, bus_out=4'hA, done pulses 3 cycles after start-accept, busy high 2 cycles.
- Load reg0=4'h5 from ext, then src_sel=0, dst_sel=3, dst_addr=4'hE, len=3 → RAM[E], RAM[F], RAM[0], RAM[1] all =4'h5 (wrap); done at cycle 9.
- RAM[2..4]=3,7,9; src_sel=3, src_addr=2, dst_sel=3, dst_addr=8, len=2 → RAM[8..A]=3,7,9; source words unchanged.
- Illegal request: dst_sel=4 (ext), src_sel=0 → err and done high together 1 cycle after accept; registers and RAM unchanged.
- start pulsed again during busy → ignored; exactly one done pulse.
- rst_n low mid-block copy → busy=0 and all regs=0 immediately.
- Optional: with BUS_XFER_COUNT_EN, after 16-word + 1-word transfers xfer_cnt=17.
